snake_game_core: RTL and testbench

//  Game-state engine for a 30x30-cell Snake game. Holds the snake body and the food cell, and

---
 rtl/snake_game_core.sv | 186 ++++++++++++++++++
 tb/tb_snake_game_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/snake_game_core.sv
// snake_game_core
// Game-state engine for a 30x30 Snake game. It stores the snake body as a list
// of cell indices (col + row*GRID) and keeps the head column/row alongside, so
// that moves need no division. It also tracks the food cell, the score and the
// sticky won/lost flags, and answers per-cell display queries one cycle late.
// Ports:
//   master_clk     system clock, all state changes on its rising edge
//   rst            synchronous active-high reset
//   game_speed_clk slow square wave; each rising edge allows one step
//   direction      requested move: 0=left 1=right 2=up 3=down
//   index          cell queried by the display
//   score          food eaten since reset
//   won / lost     sticky game-over flags
//   is_snake       queried cell (previous cycle) holds a live segment
//   is_food        queried cell (previous cycle) holds valid food
module snake_game_core #(
  parameter int GRID     = 30,
  parameter int MAX_LEN  = 30,
  parameter int WIN      = 18,
  parameter int INIT_LEN = 3
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic       game_speed_clk,
  input  logic [1:0] direction,
  input  logic [9:0] index,
  output logic [9:0] score,
  output logic       won,
  output logic       lost,
  output logic       is_snake,
  output logic       is_food
);

  localparam logic [9:0] CELLS     = 10'(GRID * GRID);
  localparam logic [9:0] ROW_STEP  = 10'(GRID);
  localparam logic [4:0] EDGE      = 5'(GRID - 1);
  localparam logic [4:0] LEN_MAX   = 5'(MAX_LEN);
  localparam logic [9:0] WIN_SCORE = 10'(WIN);

  logic       spd_q, spd_d, step_q, step_d;
  logic [9:0] seg_q [MAX_LEN];
  logic [9:0] seg_d [MAX_LEN];
  logic [4:0] head_col_q, head_col_d, head_row_q, head_row_d, len_q, len_d;
  logic [1:0] last_dir_q, last_dir_d;
  logic [9:0] food_q, food_d, score_q, score_d, lfsr_q, lfsr_d;
  logic       food_valid_q, food_valid_d, won_q, won_d, lost_q, lost_d;
  logic       is_snake_q, is_snake_d, is_food_q, is_food_d;

  logic [1:0] mv_dir;
  logic [4:0] nh_col, nh_row;
  logic [9:0] nh_idx, cand;
  logic       off_grid, grow, self_hit, cand_hit, snake_hit;

  // Candidate move: resolve reversal, detect wall exit, food and self collision.
  always_comb begin
    // A request to reverse is ignored; the snake keeps its last heading.
    if (direction == (last_dir_q ^ 2'd1)) mv_dir = last_dir_q;
    else                                  mv_dir = direction;
    off_grid = 1'b0;
    nh_col   = head_col_q;
    nh_row   = head_row_q;
    nh_idx   = seg_q[0];
    case (mv_dir)
      2'd0: begin off_grid = (head_col_q == 5'd0); nh_col = head_col_q - 5'd1; nh_idx = seg_q[0] - 10'd1;    end
      2'd1: begin off_grid = (head_col_q == EDGE); nh_col = head_col_q + 5'd1; nh_idx = seg_q[0] + 10'd1;    end
      2'd2: begin off_grid = (head_row_q == 5'd0); nh_row = head_row_q - 5'd1; nh_idx = seg_q[0] - ROW_STEP; end
      2'd3: begin off_grid = (head_row_q == EDGE); nh_row = head_row_q + 5'd1; nh_idx = seg_q[0] + ROW_STEP; end
      default: begin off_grid = 1'b1; end
    endcase
    grow = food_valid_q && !off_grid && (nh_idx == food_q);
    // Without growth the tail vacates its cell this step, so it cannot be hit.
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      self_hit = self_hit | ((seg_q[i] == nh_idx) &&
                 (((5'(i) + 5'd1) < len_q) || (grow && (5'(i) < len_q))));
    end
  end

  // Food respawn candidate and display query hits against live segments.
  always_comb begin
    if (lfsr_q >= CELLS) cand = lfsr_q - CELLS;
    else                 cand = lfsr_q;
    cand_hit  = 1'b0;
    snake_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      cand_hit  = cand_hit  | ((5'(i) < len_q) && (seg_q[i] == cand));
      snake_hit = snake_hit | ((5'(i) < len_q) && (seg_q[i] == index));
    end
    is_snake_d = (index < CELLS) && snake_hit;
    is_food_d  = (index < CELLS) && food_valid_q && (food_q == index) && !snake_hit;
  end

  // Next-state: tick detection, step execution, food respawn, LFSR.
  always_comb begin
    spd_d        = game_speed_clk;
    step_d       = game_speed_clk & ~spd_q;
    lfsr_d       = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    seg_d        = seg_q;
    head_col_d   = head_col_q;
    head_row_d   = head_row_q;
    len_d        = len_q;
    last_dir_d   = last_dir_q;
    food_d       = food_q;
    food_valid_d = food_valid_q;
    score_d      = score_q;
    won_d        = won_q;
    lost_d       = lost_q;
    if (step_q && !won_q && !lost_q) begin
      if (off_grid || self_hit) begin
        lost_d = 1'b1;
      end else begin
        for (int i = MAX_LEN - 1; i > 0; i--) seg_d[i] = seg_q[i - 1];
        seg_d[0]   = nh_idx;
        head_col_d = nh_col;
        head_row_d = nh_row;
        last_dir_d = mv_dir;
        if (grow) begin
          if (len_q == LEN_MAX) len_d = len_q;
          else                  len_d = len_q + 5'd1;
          score_d      = score_q + 10'd1;
          food_valid_d = 1'b0;
          if ((score_q + 10'd1) == WIN_SCORE) won_d = 1'b1;
          else                                won_d = won_q;
        end else begin
          len_d = len_q;
        end
      end
    end else begin
      lost_d = lost_q;
    end
    // food_valid_q low means no grow can happen this cycle, so no conflict.
    if (!food_valid_q && !cand_hit) begin
      food_d       = cand;
      food_valid_d = 1'b1;
    end else begin
      food_d = food_d;
    end
  end

  // State registers with synchronous reset to the opening position.
  always_ff @(posedge master_clk) begin
    if (rst) begin
      spd_q        <= 1'b0;
      step_q       <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= 10'd0;
      seg_q[0]     <= 10'(4 + 14 * GRID);
      seg_q[1]     <= 10'(3 + 14 * GRID);
      seg_q[2]     <= 10'(2 + 14 * GRID);
      head_col_q   <= 5'd4;
      head_row_q   <= 5'd14;
      len_q        <= 5'(INIT_LEN);
      last_dir_q   <= 2'd1;
      food_q       <= 10'(20 + 14 * GRID);
      food_valid_q <= 1'b1;
      score_q      <= 10'd0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      is_snake_q   <= 1'b0;
      is_food_q    <= 1'b0;
      lfsr_q       <= 10'h2A5;
    end else begin
      spd_q        <= spd_d;
      step_q       <= step_d;
      seg_q        <= seg_d;
      head_col_q   <= head_col_d;
      head_row_q   <= head_row_d;
      len_q        <= len_d;
      last_dir_q   <= last_dir_d;
      food_q       <= food_d;
      food_valid_q <= food_valid_d;
      score_q      <= score_d;
      won_q        <= won_d;
      lost_q       <= lost_d;
      is_snake_q   <= is_snake_d;
      is_food_q    <= is_food_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign score    = score_q;
  assign won      = won_q;
  assign lost     = lost_q;
  assign is_snake = is_snake_q;
  assign is_food  = is_food_q;

endmodule

// File: tb/tb_snake_game_core.sv
// Directed bench for snake_game_core. Long runs steer the snake along a
// Hamiltonian cycle of the grid (tracked by the bench's own head model) so it
// eventually eats every food item without ever colliding with itself.
module tb_snake_game_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gsc = 1'b0;
  logic [1:0] direction = 2'd1;
  logic [9:0] index = 10'd0;
  logic [9:0] score;
  logic       won, lost, is_snake, is_food;

  int checks = 0;
  int errors = 0;
  int hc, hr, straight;
  logic [1:0] last_mv;
  logic sn, fd, found;
  int fcount, fidx, s5;
  logic [1:0] pd, dd;

  snake_game_core dut (
    .master_clk(clk), .rst(rst), .game_speed_clk(gsc), .direction(direction),
    .index(index), .score(score), .won(won), .lost(lost),
    .is_snake(is_snake), .is_food(is_food)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1; gsc = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    hc = 4; hr = 14; last_mv = 2'd1; straight = 0;
  endtask

  // One game tick; returns after the resulting step has been applied.
  task automatic tick();
    @(negedge clk) gsc = 1'b1;
    @(negedge clk) gsc = 1'b0;
    @(negedge clk);
  endtask

  task automatic query(input int idx, output logic s, output logic f);
    @(negedge clk) index = 10'(idx);
    @(posedge clk);
    #1;
    s = is_snake;
    f = is_food;
  endtask

  // Hamiltonian cycle: row 0 runs left, columns serpentine through rows 1..29.
  function automatic logic [1:0] ham_dir(input int c, input int r);
    if (r == 0) return (c == 0) ? 2'd3 : 2'd0;
    if (c % 2 == 0) return (r == 29) ? 2'd1 : 2'd3;
    if (r == 1) return (c == 29) ? 2'd2 : 2'd1;
    return 2'd2;
  endfunction

  task automatic ham_tick();
    logic [1:0] d;
    d = ham_dir(hc, hr);
    direction = d;
    tick();
    case (d)
      2'd0:    hc--;
      2'd1:    hc++;
      2'd2:    hr--;
      default: hr++;
    endcase
    if (d == last_mv) straight++;
    else              straight = 1;
    last_mv = d;
  endtask

  initial begin
    // 1: reset state and initial queries
    index = 10'd440;
    @(negedge clk); @(negedge clk);
    chk("rst_is_food", is_food, 0);
    chk("rst_is_snake", is_snake, 0);
    chk("rst_score", score, 0);
    chk("rst_won", won, 0);
    chk("rst_lost", lost, 0);
    do_reset();
    query(424, sn, fd); chk("t1_snake424", sn, 1);
    query(423, sn, fd); chk("t1_snake423", sn, 1);
    query(422, sn, fd); chk("t1_snake422", sn, 1);
    query(440, sn, fd); chk("t1_snake440", sn, 0); chk("t1_food440", fd, 1);
    query(900, sn, fd); chk("t1_snake900", sn, 0); chk("t1_food900", fd, 0);

    // 2: run right into the food
    direction = 2'd1;
    repeat (16) tick();
    chk("t2_score", score, 1);
    chk("t2_lost", lost, 0);
    query(440, sn, fd); chk("t2_head440", sn, 1);
    query(437, sn, fd); chk("t2_tail437", sn, 1);
    query(436, sn, fd); chk("t2_free436", sn, 0);
    repeat (900) @(posedge clk);
    fcount = 0; fidx = -1;
    for (int i = 0; i < 900; i++) begin
      query(i, sn, fd);
      if (fd) begin fcount++; fidx = i; end
    end
    chk("t2_food_count", fcount, 1);
    chk("t2_food_off_snake", (fidx >= 437 && fidx <= 440) ? 1 : 0, 0);

    // 3: run into the right wall
    do_reset();
    direction = 2'd1;
    repeat (25) tick();
    chk("t3_lost_before_wall", lost, 0);
    tick();
    chk("t3_lost", lost, 1);
    chk("t3_score", score, 1);
    query(449, sn, fd); chk("t3_head449", sn, 1);
    query(446, sn, fd); chk("t3_tail446", sn, 1);
    query(445, sn, fd); chk("t3_free445", sn, 0);
    repeat (3) tick();
    chk("t3_lost_sticky", lost, 1);
    chk("t3_score_frozen", score, 1);
    query(449, sn, fd); chk("t3_head_frozen", sn, 1);
    query(445, sn, fd); chk("t3_free_frozen", sn, 0);

    // 4: reverse request right after reset is ignored
    do_reset();
    direction = 2'd0;
    tick();
    chk("t4_lost", lost, 0);
    query(425, sn, fd); chk("t4_head425", sn, 1);
    query(422, sn, fd); chk("t4_old_tail", sn, 0);
    tick();
    query(426, sn, fd); chk("t4_head426", sn, 1);
    query(423, sn, fd); chk("t4_old_tail2", sn, 0);

    // 5: grow to length >= 5, then turn back into the body
    do_reset();
    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      ham_tick();
      if (score >= 10'd2 && straight >= 6 && last_mv[1] && hr >= 5 && hr <= 24) found = 1'b1;
    end
    chk("t5_setup_reached", found, 1);
    if (found) begin
      s5 = int'(score);
      chk("t5_len_ge5", (s5 >= 2) ? 1 : 0, 1);
      pd = (hc > 0) ? 2'd0 : 2'd1;
      dd = last_mv;
      direction = pd;          tick();
      direction = dd ^ 2'd1;   tick();
      chk("t5_lost_mid", lost, 0);
      direction = pd ^ 2'd1;   tick();
      chk("t5_lost", lost, 1);
      chk("t5_score_unchanged", score, 32'(s5));
    end

    // 6: eat until won, then reset
    do_reset();
    for (int n = 0; n < 17000 && !won; n++) ham_tick();
    chk("t6_won", won, 1);
    chk("t6_score", score, 18);
    chk("t6_lost", lost, 0);
    repeat (3) tick();
    chk("t6_won_sticky", won, 1);
    chk("t6_score_frozen", score, 18);
    do_reset();
    chk("t6_rst_score", score, 0);
    chk("t6_rst_won", won, 0);
    query(424, sn, fd); chk("t6_rst_head", sn, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
